// File: rtl/mov_sum_pkg.sv
// rtl/mov_sum_pkg.sv - shared widths, FSM state and sample/sum types for the moving-window sum
package mov_sum_pkg;

  localparam int DATA_W     = 10;
  localparam int SUM_W      = 32;
  localparam int WIN_AW     = 8;
  localparam int HIST_DEPTH = 1 << WIN_AW;

  localparam logic [WIN_AW-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic signed [DATA_W:0]  sample_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  // One extra bit of headroom so |-512| = 512 is representable.
  function automatic sample_t to_sample(input logic [DATA_W-1:0] raw, input logic use_abs);
    sample_t s;
    s = sample_t'($signed(raw));
    if (use_abs && s[DATA_W]) begin
      return -s;
    end
    return s;
  endfunction

endpackage

// File: rtl/mov_sum_hist.sv
// rtl/mov_sum_hist.sv - sample history ring buffer, one sync write port, one async read port
module mov_sum_hist
  import mov_sum_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [WIN_AW-1:0] waddr_i,
  input  sample_t           wdata_i,
  input  logic [WIN_AW-1:0] raddr_i,
  output sample_t           rdata_o
);

  sample_t mem_q [HIST_DEPTH];

  // No reset: entries are only read once the window has been filled since start.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mov_sum_window.sv
// rtl/mov_sum_window.sv - streaming moving-window sum over signed ADC samples
module mov_sum_window
  import mov_sum_pkg::*;
(
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  output logic                ap_ready,
  input  logic [WIN_AW-1:0]   window_width_V,
  input  logic                absolute_value_V,
  input  logic [DATA_W-1:0]   datain_V_dout,
  input  logic                datain_V_empty_n,
  output logic                datain_V_read,
  output logic [SUM_W-1:0]    sumout_V,
  output logic                sumout_V_ap_vld
);

  state_e            state_q;
  logic [WIN_AW-1:0] win_q;
  logic              abs_q;
  logic [WIN_AW-1:0] cnt_q;
  logic [WIN_AW-1:0] ptr_q;
  sum_t              sum_q;
  logic              vld_q;
  logic              ready_q;

  logic              rd_fire;
  sample_t           x_new;
  sample_t           x_old;
  sample_t           hist_rdata;
  logic [WIN_AW-1:0] hist_raddr;
  sum_t              sum_d;
  logic [WIN_AW-1:0] cnt_d;

  assign rd_fire    = (state_q == RUN) && datain_V_empty_n;
  assign hist_raddr = ptr_q - win_q;

  always_comb begin
    x_new = to_sample(datain_V_dout, abs_q);
    x_old = '0;
    // W=0 retires the incoming sample itself; the RAM still holds the stale entry at ptr.
    if (win_q == '0) begin
      x_old = x_new;
    end else if (cnt_q >= win_q) begin
      x_old = hist_rdata;
    end
    sum_d = sum_q + sum_t'(x_new) - sum_t'(x_old);
    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  mov_sum_hist u_hist (
    .clk_i   (ap_clk),
    .we_i    (rd_fire),
    .waddr_i (ptr_q),
    .wdata_i (x_new),
    .raddr_i (hist_raddr),
    .rdata_o (hist_rdata)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      abs_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sum_q   <= '0;
      vld_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      vld_q   <= 1'b0;
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            win_q   <= window_width_V;
            abs_q   <= absolute_value_V;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sum_q   <= '0;
            ready_q <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (rd_fire) begin
            sum_q <= sum_d;
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_d;
            vld_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ap_done         = 1'b0;
  assign ap_idle         = (state_q == IDLE);
  assign ap_ready        = ready_q;
  assign datain_V_read   = rd_fire;
  assign sumout_V        = sum_q;
  assign sumout_V_ap_vld = vld_q;

endmodule

// File: tb/tb_mov_sum_window.sv
// tb/tb_mov_sum_window.sv - directed self-checking bench for mov_sum_window
module tb_mov_sum_window;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [7:0]  window_width_V = '0;
  logic        absolute_value_V = 1'b0;
  logic [9:0]  datain_V_dout = '0;
  logic        datain_V_empty_n = 1'b0;
  logic        datain_V_read;
  logic [31:0] sumout_V;
  logic        sumout_V_ap_vld;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         new_seg;
    logic [7:0] w;
    logic       abs_en;
    int         sample;
    int         exp_sum;
  } vec_t;

  vec_t vecs[$];

  mov_sum_window dut (
    .ap_clk           (ap_clk),
    .ap_rst_n         (ap_rst_n),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .window_width_V   (window_width_V),
    .absolute_value_V (absolute_value_V),
    .datain_V_dout    (datain_V_dout),
    .datain_V_empty_n (datain_V_empty_n),
    .datain_V_read    (datain_V_read),
    .sumout_V         (sumout_V),
    .sumout_V_ap_vld  (sumout_V_ap_vld)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    datain_V_empty_n = 1'b0;
    #2;
    ap_rst_n = 1'b1;
    tick();
  endtask

  task automatic do_start(input logic [7:0] w, input logic abs_en);
    window_width_V   = w;
    absolute_value_V = abs_en;
    ap_start = 1'b1;
    check("idle_before_start", ap_idle, 1);
    tick();
    ap_start = 1'b0;
    window_width_V = 8'd77;
    absolute_value_V = ~abs_en;
    check("ready_start_cycle", ap_ready, 1);
    check("idle_after_start", ap_idle, 0);
    check("done_after_start", ap_done, 0);
  endtask

  task automatic do_sample(input string name, input int s, input int exp_sum);
    datain_V_dout = s[9:0];
    datain_V_empty_n = 1'b1;
    #1;
    check({name, "_read"}, datain_V_read, 1);
    tick();
    datain_V_empty_n = 1'b0;
    check({name, "_sum"}, $signed(sumout_V), exp_sum);
    check({name, "_vld"}, sumout_V_ap_vld, 1);
    check({name, "_ready"}, ap_ready, 0);
    check({name, "_done"}, ap_done, 0);
  endtask

  initial begin
    vecs.push_back('{1'b1, 8'd3, 1'b0, 1, 1});
    vecs.push_back('{1'b0, 8'd3, 1'b0, 2, 3});
    vecs.push_back('{1'b0, 8'd3, 1'b0, 3, 6});
    vecs.push_back('{1'b0, 8'd3, 1'b0, 4, 9});
    vecs.push_back('{1'b0, 8'd3, 1'b0, 5, 12});
    vecs.push_back('{1'b1, 8'd2, 1'b1, -5, 5});
    vecs.push_back('{1'b0, 8'd2, 1'b1, -5, 10});
    vecs.push_back('{1'b0, 8'd2, 1'b1, 7, 12});
    vecs.push_back('{1'b0, 8'd2, 1'b1, -512, 519});
    vecs.push_back('{1'b1, 8'd2, 1'b0, -5, -5});
    vecs.push_back('{1'b0, 8'd2, 1'b0, -5, -10});
    vecs.push_back('{1'b0, 8'd2, 1'b0, 7, 2});
    vecs.push_back('{1'b0, 8'd2, 1'b0, -512, -505});
    vecs.push_back('{1'b1, 8'd0, 1'b0, 7, 0});
    vecs.push_back('{1'b0, 8'd0, 1'b0, -300, 0});
    vecs.push_back('{1'b0, 8'd0, 1'b0, 511, 0});
    vecs.push_back('{1'b1, 8'd1, 1'b1, -100, 100});
    vecs.push_back('{1'b0, 8'd1, 1'b1, 33, 33});

    // Reset state, including read gating while idle with data available.
    #2;
    datain_V_empty_n = 1'b1;
    #1;
    check("rst_idle", ap_idle, 1);
    check("rst_ready", ap_ready, 0);
    check("rst_vld", sumout_V_ap_vld, 0);
    check("rst_sum", $signed(sumout_V), 0);
    check("rst_done", ap_done, 0);
    check("idle_no_read", datain_V_read, 0);
    datain_V_empty_n = 1'b0;
    ap_rst_n = 1'b1;
    tick();
    check("idle_hold", ap_idle, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].new_seg) begin
        do_reset();
        do_start(vecs[i].w, vecs[i].abs_en);
      end
      do_sample($sformatf("vec%0d", i), vecs[i].sample, vecs[i].exp_sum);
    end

    // Full 255-sample window of |-512|: ramp then plateau.
    do_reset();
    do_start(8'd255, 1'b1);
    for (int n = 1; n <= 300; n++) begin
      do_sample($sformatf("w255_n%0d", n), -512, ((n < 255) ? n : 255) * 512);
    end

    // FIFO empty stall, with ap_start asserted during RUN to show it is ignored.
    do_reset();
    do_start(8'd2, 1'b0);
    do_sample("stall_a", 1, 1);
    do_sample("stall_b", 2, 3);
    ap_start = 1'b1;
    window_width_V = 8'd0;
    for (int k = 0; k < 4; k++) begin
      datain_V_empty_n = 1'b0;
      #1;
      check("stall_read", datain_V_read, 0);
      tick();
      check("stall_vld", sumout_V_ap_vld, 0);
      check("stall_sum", $signed(sumout_V), 3);
      check("stall_ready", ap_ready, 0);
      check("stall_idle", ap_idle, 0);
    end
    do_sample("stall_c", 3, 5);
    ap_start = 1'b0;
    do_sample("stall_d", 4, 7);

    // Asynchronous reset mid-RUN, then restart from empty history.
    do_reset();
    do_start(8'd3, 1'b0);
    do_sample("abort_a", 50, 50);
    do_sample("abort_b", 60, 110);
    ap_rst_n = 1'b0;
    #1;
    check("abort_sum", $signed(sumout_V), 0);
    check("abort_idle", ap_idle, 1);
    check("abort_vld", sumout_V_ap_vld, 0);
    #2;
    ap_rst_n = 1'b1;
    tick();
    do_start(8'd3, 1'b0);
    do_sample("restart_a", 4, 4);
    do_sample("restart_b", -9, -5);
    do_sample("restart_c", 10, 5);
    do_sample("restart_d", 1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
